// File: rtl/core_pkg.sv
// Shared definitions for the core front end: datapath width, fetch FSM
// states and default reset/halt constants.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [XLEN-1:0] HALT_INSN_DEF = 32'h0000_0073;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Next-PC selection: jump > branch > sequential priority mux plus range check.
// Purely combinational.
// With FETCH_MISALIGN_TRAP_EN defined, redirect targets pass through unchanged
// and a misaligned flag is produced; otherwise their low two bits are cleared.
module next_pc_sel
    import core_pkg::*;
#(
    parameter int MEM_SIZE = 256
) (
    input  logic [XLEN-1:0] pc,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] next_pc,
    output logic            out_of_range
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misaligned
`endif
);

    // One past the last legal byte address, one bit wider than the PC.
    localparam logic [XLEN:0] LIMIT = (XLEN+1)'(MEM_SIZE) << 2;

    logic [XLEN:0]   seq_sum;
    logic [XLEN-1:0] raw_target;
    logic            redirect;

    // Pick the target by priority, then align it and check it against memory.
    always_comb begin
        seq_sum  = {1'b0, pc} + (XLEN+1)'(4);
        redirect = jump | branch_taken;

        if (jump) begin
            raw_target = jump_target;
        end else if (branch_taken) begin
            raw_target = branch_target;
        end else begin
            raw_target = seq_sum[XLEN-1:0];
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned = redirect && (raw_target[1:0] != 2'b00);
        next_pc    = raw_target;
`else
        next_pc    = redirect ? {raw_target[XLEN-1:2], 2'b00} : raw_target;
`endif

        // A carry out of pc + 4 means the address wrapped past the top.
        out_of_range = (!redirect && seq_sum[XLEN]) || ({1'b0, next_pc} >= LIMIT);
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC register, BOOT/RUN/HALT FSM and
// accepted-fetch counter. Fetch is zero-latency; the PC addresses I_MEM
// directly and the returned word is presented in the same cycle.
// Optional feature: FETCH_MISALIGN_TRAP_EN traps misaligned redirects.
module fetch_pc_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter int              MEM_SIZE  = 256,
    parameter logic [XLEN-1:0] HALT_INSN = HALT_INSN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_data_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            instr_valid_o,
    output logic            halted_o,
    output logic [XLEN-1:0] fetch_count_o
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_o
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] count_q, count_d;
    logic [XLEN-1:0] next_pc;
    logic            out_of_range;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misaligned;
    logic            misalign_q, misalign_d;
`endif

    next_pc_sel #(
        .MEM_SIZE (MEM_SIZE)
    ) u_next_pc_sel (
        .pc            (pc_q),
        .jump          (jump_i),
        .jump_target   (jump_target_i),
        .branch_taken  (branch_taken_i),
        .branch_target (branch_target_i),
        .next_pc       (next_pc),
        .out_of_range  (out_of_range)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misaligned    (misaligned)
`endif
    );

    // State, PC, counter and sticky trap flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            count_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Next-state logic: a halt instruction beats any redirect; stalls freeze all.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (!stall_i) begin
                    count_d = count_q + XLEN'(1);
                    if (imem_data_i == HALT_INSN) begin
                        state_d = HALT;
                    end
`ifdef FETCH_MISALIGN_TRAP_EN
                    else if (misaligned) begin
                        state_d    = HALT;
                        misalign_d = 1'b1;
                    end
`endif
                    else if (out_of_range) begin
                        state_d = HALT;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_q + XLEN'(4);
    assign instr_o       = imem_data_i;
    assign instr_valid_o = (state_q == RUN);
    assign halted_o      = (state_q == HALT);
    assign fetch_count_o = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_o    = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed test-plan steps followed by
// randomized cycles, all compared against a behavioural model of the fetch rules.
module tb_fetch_pc_unit;

    localparam logic [31:0] HALT_WORD = 32'h0000_0073;
    localparam longint      MEM_BYTES = 256 * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_target_i = '0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] imem_data_i = '0;
    logic [31:0] imem_addr_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        instr_valid_o;
    logic        halted_o;
    logic [31:0] fetch_count_o;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_count;
    bit          m_started;
    bit          m_halted;
    bit          m_misalign;

    fetch_pc_unit #(
        .RESET_PC  (32'h0000_0000),
        .MEM_SIZE  (256),
        .HALT_INSN (32'h0000_0073)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_addr_o     (imem_addr_o),
        .imem_data_i     (imem_data_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .instr_valid_o   (instr_valid_o),
        .halted_o        (halted_o),
        .fetch_count_o   (fetch_count_o)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_o      (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT_WORD) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic model_reset();
        m_pc       = 32'h0;
        m_count    = 32'h0;
        m_started  = 1'b0;
        m_halted   = 1'b0;
        m_misalign = 1'b0;
    endtask

    // Apply the fetch rules for one rising edge, using the inputs currently driven.
    task automatic model_edge();
        longint target;
        bit     redirect;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (!m_halted && !stall_i) begin
            m_count = m_count + 32'd1;
            if (imem_data_i == HALT_WORD) begin
                m_halted = 1'b1;
            end else begin
                redirect = jump_i || branch_taken_i;
                if (jump_i)              target = longint'(jump_target_i);
                else if (branch_taken_i) target = longint'(branch_target_i);
                else                     target = longint'(m_pc) + 4;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (redirect && (target % 4) != 0) begin
                    m_halted   = 1'b1;
                    m_misalign = 1'b1;
                end else
`else
                if (redirect) target = target - (target % 4);
`endif
                if (target >= MEM_BYTES) m_halted = 1'b1;
                else                     m_pc = target[31:0];
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        check_eq({tag, ":pc"}, pc_o, m_pc);
        check_eq({tag, ":addr"}, imem_addr_o, m_pc);
        check_eq({tag, ":pc4"}, pc_plus4_o, m_pc + 32'd4);
        check_eq({tag, ":instr"}, instr_o, imem_data_i);
        check_eq({tag, ":valid"}, {31'b0, instr_valid_o}, {31'b0, m_started && !m_halted});
        check_eq({tag, ":halted"}, {31'b0, halted_o}, {31'b0, m_halted});
        check_eq({tag, ":count"}, fetch_count_o, m_count);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq({tag, ":misalign"}, {31'b0, misalign_o}, {31'b0, m_misalign});
`endif
    endtask

    // Drive one cycle of inputs, clock it, advance the model and compare.
    task automatic applyStimulus(input string tag, input logic st, input logic jp, input logic [31:0] jt,
                                 input logic br, input logic [31:0] bt, input logic [31:0] data);
        stall_i         = st;
        jump_i          = jp;
        jump_target_i   = jt;
        branch_taken_i  = br;
        branch_target_i = bt;
        imem_data_i     = data;
        #1;
        check_eq({tag, ":pre_instr"}, instr_o, data);
        model_edge();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic doReset(input string tag);
        stall_i = 1'b0; jump_i = 1'b0; branch_taken_i = 1'b0;
        imem_data_i = rand_word();
        #2 rst_n = 1'b0;
        #2;
        model_reset();
        checkOutput(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        doReset("reset");

        // Reset and boot
        applyStimulus("boot0", 0, 0, 0, 0, 0, rand_word());
        check_eq("boot0_pc", pc_o, 32'h0);
        applyStimulus("boot1", 0, 0, 0, 0, 0, rand_word());
        check_eq("boot1_pc", pc_o, 32'h4);
        applyStimulus("boot2", 0, 0, 0, 0, 0, rand_word());
        check_eq("boot2_pc", pc_o, 32'h8);
        check_eq("boot2_count", fetch_count_o, 32'd2);

        // Redirect priority
        applyStimulus("jump_wins", 0, 1, 32'h40, 1, 32'h20, rand_word());
        check_eq("jump_wins_pc", pc_o, 32'h40);
        applyStimulus("branch", 0, 0, 0, 1, 32'h10, rand_word());
        check_eq("branch_pc", pc_o, 32'h10);

        // Stall with a pending jump
        applyStimulus("to_0c", 0, 1, 32'h0C, 0, 0, rand_word());
        applyStimulus("stall0", 1, 1, 32'h80, 0, 0, rand_word());
        applyStimulus("stall1", 1, 1, 32'h80, 0, 0, rand_word());
        check_eq("stall_pc", pc_o, 32'h0C);
        applyStimulus("unstall", 0, 0, 0, 0, 0, rand_word());
        check_eq("unstall_pc", pc_o, 32'h10);

        // Halt instruction beats a simultaneous jump
        applyStimulus("to_14", 0, 0, 0, 0, 0, rand_word());
        applyStimulus("halt", 0, 1, 32'h40, 0, 0, HALT_WORD);
        check_eq("halt_flag", {31'b0, halted_o}, 32'd1);
        check_eq("halt_pc", pc_o, 32'h14);
        applyStimulus("halt_ign0", 0, 1, 32'h40, 1, 32'h20, rand_word());
        applyStimulus("halt_ign1", 0, 1, 32'h80, 0, 0, HALT_WORD);

        // Reset while halted
        doReset("reset_halted");

        // Out-of-range sequential fetch
        applyStimulus("oor_boot", 0, 0, 0, 0, 0, rand_word());
        applyStimulus("oor_jump", 0, 1, 32'h3F0, 0, 0, rand_word());
        for (int i = 0; i < 4; i++) applyStimulus("oor_seq", 0, 0, 0, 0, 0, rand_word());
        check_eq("oor_halted", {31'b0, halted_o}, 32'd1);
        check_eq("oor_pc", pc_o, 32'h3FC);

        // Misaligned jump
        doReset("reset_mis");
        applyStimulus("mis_boot", 0, 0, 0, 0, 0, rand_word());
        applyStimulus("mis_jump", 0, 1, 32'h22, 0, 0, rand_word());
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("mis_trap", {31'b0, misalign_o}, 32'd1);
        check_eq("mis_halted", {31'b0, halted_o}, 32'd1);
`else
        check_eq("mis_align_pc", pc_o, 32'h20);
`endif

        // Randomized cycles with occasional resets
        doReset("reset_rand");
        for (int i = 0; i < 600; i++) begin
            logic        st, jp, br;
            logic [31:0] jt, bt, data;
            if ($urandom_range(0, 99) < 2) begin
                doReset("rand_reset");
            end else begin
                st = ($urandom_range(0, 99) < 20);
                jp = ($urandom_range(0, 99) < 10);
                br = ($urandom_range(0, 99) < 15);
                jt = $urandom_range(0, 32'h41F);
                bt = $urandom_range(0, 32'h41F);
`ifdef FETCH_MISALIGN_TRAP_EN
                if ($urandom_range(0, 3) != 0) begin
                    jt = jt & ~32'h3;
                    bt = bt & ~32'h3;
                end
`endif
                data = ($urandom_range(0, 99) < 3) ? HALT_WORD : rand_word();
                applyStimulus("rand", st, jp, jt, br, bt, data);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end of the single-cycle core: owns the program counter, drives the address of the instruction memory (`I_MEM`) and presents the returned word, tagged with its PC and a valid flag, to decode. It selects the next PC from sequential, branch and jump sources, honours a stall request, and stops the core cleanly on a halt instruction or an out-of-range fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `MEM_SIZE`, 256, instruction memory depth in 32-bit words; the legal byte range is 0 to MEM_SIZE*4-1.
- `HALT_INSN`, 32'h0000_0073, instruction encoding that halts fetch.
- `clk  in  1`  core clock; all state updates on the rising edge.
- `rst_n  in  1`  asynchronous, active-low reset.
- `stall_i  in  1`  hold the PC and counter this cycle.
- `jump_i  in  1`  unconditional redirect request.
- `jump_target_i  in  32`  jump byte address.
- `branch_taken_i  in  1`  taken-branch redirect request.
- `branch_target_i  in  32`  branch byte address.
- `imem_addr_o  out  32`  address to `I_MEM`; always equals `pc_o`.
- `imem_data_i  in  32`  `I_MEM` read data (combinational).
- `instr_o  out  32`  instruction to decode.
- `pc_o  out  32`  PC of `instr_o`.
- `pc_plus4_o  out  32`  `pc_o + 4`, used as the link value.
- `instr_valid_o  out  1`  `instr_o` is executable this cycle.
- `halted_o  out  1`  fetch has stopped permanently until reset.
- `fetch_count_o  out  32`  number of instructions fetched and accepted.
- `misalign_o  out  1`  misaligned redirect trapped (present only with `FETCH_MISALIGN_TRAP_EN`).

## Operation
- FSM states: BOOT, RUN, HALT.
- **BOOT:** the state entered on reset. `instr_valid_o` is 0 and the PC holds. The FSM moves to RUN on the next edge unconditionally.
- **RUN:**
  - `instr_o = imem_data_i` and `instr_valid_o = 1`.
  - Next-PC priority: `jump_i` > `branch_taken_i` > `pc + 4`. The selected target loads on the next edge.
- **Stall:** `stall_i = 1` in RUN holds the PC, the counter and the state. Redirect inputs are ignored that cycle. `instr_valid_o` stays 1, and the same instruction is presented again.
- **Accepted cycle:** a cycle in RUN with `stall_i = 0`.
  - `fetch_count_o` increments by 1 and wraps modulo 2^32.
  - If `instr_o == HALT_INSN`, the next state is HALT and the PC holds. The halt instruction itself is counted.
- **Out-of-range fetch:** if the selected next PC is ≥ MEM_SIZE*4, the next state is HALT and the PC holds its current value.
- **HALT:** `halted_o = 1` and `instr_valid_o = 0`. All inputs are ignored; only reset exits this state.
- **Arithmetic:** PC addition is 32-bit with wrap. A wrapped `pc + 4` is treated as out of range and halts.
- **Reset values:** PC = `RESET_PC`, state = BOOT, `fetch_count_o` = 0, `halted_o` = 0, `instr_valid_o` = 0, `misalign_o` = 0. `instr_o` follows `imem_data_i`.

## Timing
- Fetch is zero-latency: `imem_addr_o` feeds `I_MEM` combinationally, and `instr_o` is valid in the same cycle.
- A redirect sampled at edge N makes the target visible on `pc_o` immediately after edge N. There is no delay slot and no bubble.
- After reset release, the first valid instruction appears one cycle after the first rising edge (BOOT costs one cycle).
- Simultaneous `jump_i` and `branch_taken_i`: the jump wins.
- Halt instruction with `jump_i` asserted in the same cycle: halt wins.
- Reset asserted mid-operation clears all state asynchronously, regardless of the current state.

## Configuration
- `FETCH_MISALIGN_TRAP_EN`
  - **Defined:** a selected jump or branch target with `[1:0] != 0` sends the FSM to HALT and sets `misalign_o = 1`. `misalign_o` is sticky until reset, and the PC holds.
  - **Undefined:** target bits `[1:0]` are forced to 2'b00 and the port `misalign_o` is absent.

## Structure
- Shared package `core_pkg`:
  - FSM state enum `fetch_state_t` (BOOT, RUN, HALT).
  - `XLEN = 32`.
  - Default constants `RESET_PC_DEF` and `HALT_INSN_DEF`.
- Sub-module `next_pc_sel`: purely combinational priority mux and range check. It outputs `next_pc`, `out_of_range` and `misaligned`.
- The PC register, FSM and counter live in the top module.

## Test plan
- **Reset and boot:** assert `rst_n = 0`, release, apply 3 clocks with no redirects → `pc_o` = 0, 0, 4, 8; `instr_valid_o` = 0, 1, 1, 1; `fetch_count_o` = 2 after the third edge.
- **Redirect priority:** at PC 0x08, assert `jump_i` (target 0x40) and `branch_taken_i` (target 0x20) together → next `pc_o` = 0x40; then branch only to 0x10 → `pc_o` = 0x10.
- **Stall:** at PC 0x0C, hold `stall_i` for 2 cycles with `jump_i` asserted → `pc_o` stays 0x0C and `fetch_count_o` is unchanged; release → `pc_o` = 0x10.
- **Halt instruction:** at PC 0x14, drive `imem_data_i` = 32'h0000_0073 → after the edge `halted_o` = 1, `instr_valid_o` = 0, `pc_o` = 0x14, count incremented once; subsequent jumps are ignored.
- **Out-of-range fetch:** with MEM_SIZE = 256, run sequentially to PC 0x3FC → after the next edge `halted_o` = 1 and `pc_o` = 0x3FC.
- **Misaligned jump:** jump to 0x22.
  - With `FETCH_MISALIGN_TRAP_EN`: `halted_o` = 1 and `misalign_o` = 1.
  - Without it: `pc_o` = 0x20.
- **Reset mid-run:** pulse `rst_n` low while in HALT → state BOOT, `pc_o` = 0, counter 0, `halted_o` = 0.
